division_sequencer: RTL and testbench

//   Multi-cycle restoring divider with a start/done handshake for the calculator datapath.

---
 rtl/division_sequencer_if.sv | 28 ++
 rtl/division_sequencer.sv | 177 +++++++++++++++++
 tb/tb_division_sequencer.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/division_sequencer_if.sv
// Handshake/data bundle between the operation decoder and division_sequencer.
//   master (decoder)   : drives start, inputP, inputQ; observes status and results
//   slave  (sequencer) : observes request and operands; drives ready, busy, done,
//                        quotient, remainder, divideByZero
// Parameter WIDTH must match the WIDTH of the attached division_sequencer.
interface division_sequencer_if #(
    parameter int WIDTH = 16
) ();
    logic                 start;
    logic [WIDTH-1:0]     inputP;
    logic [WIDTH-1:0]     inputQ;
    logic                 ready;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]     remainder;
    logic [1:0]           divideByZero;

    modport master (
        output start, inputP, inputQ,
        input  ready, busy, done, quotient, remainder, divideByZero
    );

    modport slave (
        input  start, inputP, inputQ,
        output ready, busy, done, quotient, remainder, divideByZero
    );
endinterface

// File: rtl/division_sequencer.sv
// Multi-cycle restoring divider with a start/done handshake.
// One quotient bit per ITER cycle; WIDTH+1 cycles from the accepting edge to done.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst   : synchronous active-high reset, highest priority
//   bus   : division_sequencer_if.slave (start/inputP/inputQ in;
//           ready/busy/done/quotient/remainder/divideByZero out)
// Build option: define DIV_SIGNED_EN for two's complement operands
// (truncating quotient, remainder carries the dividend's sign).
//
// state | meaning
// IDLE  | waiting for start, previous result held
// ITER  | one restoring step per cycle, counter runs WIDTH-1 down to 0
// DONE  | one-cycle done pulse, results valid, start accepted again
module division_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    division_sequencer_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     rem_q, rem_d;
    logic [WIDTH-1:0]     dvd_q, dvd_d;
    logic [WIDTH-1:0]     dvs_q, dvs_d;
    logic [2*WIDTH-1:0]   quotient_q, quotient_d;
    logic [WIDTH-1:0]     remainder_q, remainder_d;
    logic [1:0]           dbz_q, dbz_d;

    logic [WIDTH:0]       rem_shift;
    logic [WIDTH:0]       rem_diff;
    logic [WIDTH-1:0]     step_rem;
    logic [WIDTH-1:0]     step_quo;
    logic [WIDTH-1:0]     p_mag;
    logic [WIDTH-1:0]     q_mag;
    logic [2*WIDTH-1:0]   quo_out;
    logic [WIDTH-1:0]     rem_out;

`ifdef DIV_SIGNED_EN
    logic                 neg_quo_q, neg_quo_d;
    logic                 neg_rem_q, neg_rem_d;
`endif

    // The stored partial remainder is always below the divisor, so WIDTH bits
    // hold it; the shifted working value needs the extra bit. dvd_q shifts
    // dividend bits out of the top while quotient bits enter at the bottom.
    always_comb begin
        rem_shift = {rem_q, dvd_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, dvs_q};
        if (rem_diff[WIDTH]) begin
            step_rem = rem_shift[WIDTH-1:0];
        end else begin
            step_rem = rem_diff[WIDTH-1:0];
        end
        step_quo = {dvd_q[WIDTH-2:0], ~rem_diff[WIDTH]};
    end

`ifdef DIV_SIGNED_EN
    always_comb begin
        p_mag   = bus.inputP[WIDTH-1] ? -bus.inputP : bus.inputP;
        q_mag   = bus.inputQ[WIDTH-1] ? -bus.inputQ : bus.inputQ;
        quo_out = {{WIDTH{1'b0}}, step_quo};
        if (neg_quo_q) begin
            quo_out = -quo_out;
        end
        rem_out = neg_rem_q ? -step_rem : step_rem;
    end
`else
    always_comb begin
        p_mag   = bus.inputP;
        q_mag   = bus.inputQ;
        quo_out = {{WIDTH{1'b0}}, step_quo};
        rem_out = step_rem;
    end
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;
`ifdef DIV_SIGNED_EN
        neg_quo_d   = neg_quo_q;
        neg_rem_d   = neg_rem_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    if (bus.inputQ == '0) begin
                        // No iteration needed: results are known at capture.
                        state_d     = DONE;
                        quotient_d  = '0;
                        remainder_d = bus.inputP;
                        dbz_d       = 2'b01;
                    end else begin
                        state_d = ITER;
                        cnt_d   = CW'(WIDTH - 1);
                        rem_d   = '0;
                        dvd_d   = p_mag;
                        dvs_d   = q_mag;
`ifdef DIV_SIGNED_EN
                        neg_quo_d = bus.inputP[WIDTH-1] ^ bus.inputQ[WIDTH-1];
                        neg_rem_d = bus.inputP[WIDTH-1];
`endif
                    end
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            ITER: begin
                rem_d = step_rem;
                dvd_d = step_quo;
                if (cnt_q == '0) begin
                    state_d     = DONE;
                    quotient_d  = quo_out;
                    remainder_d = rem_out;
                    dbz_d       = 2'b00;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 2'b00;
`ifdef DIV_SIGNED_EN
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
`ifdef DIV_SIGNED_EN
            neg_quo_q   <= neg_quo_d;
            neg_rem_q   <= neg_rem_d;
`endif
        end
    end

    assign bus.ready        = (state_q == IDLE) || (state_q == DONE);
    assign bus.busy         = (state_q == ITER);
    assign bus.done         = (state_q == DONE);
    assign bus.quotient     = quotient_q;
    assign bus.remainder    = remainder_q;
    assign bus.divideByZero = dbz_q;
endmodule

// File: tb/tb_division_sequencer.sv
// Directed bench for division_sequencer (WIDTH=16). Honours DIV_SIGNED_EN.
module tb_division_sequencer;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;

    division_sequencer_if #(.WIDTH(W)) bus ();

    division_sequencer #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation; returns the cycle (edge 0 = accept) where done was
    // seen, or -1 if it never came, plus the number of busy cycles before it.
    task automatic run_op(input logic [W-1:0] p, input logic [W-1:0] q,
                          output int dcyc, output int busy_cnt);
        bus.start  = 1'b1;
        bus.inputP = p;
        bus.inputQ = q;
        tick();
        bus.start  = 1'b0;
        bus.inputP = W'($urandom);
        bus.inputQ = W'($urandom);
        dcyc     = -1;
        busy_cnt = 0;
        for (int c = 1; c <= 40; c++) begin
            if (bus.done) begin
                dcyc = c;
                break;
            end
            if (bus.busy) busy_cnt++;
            tick();
        end
    endtask

    task automatic op_check(input string tag, input logic [W-1:0] p, input logic [W-1:0] q,
                            input int exp_cyc, input logic [63:0] exp_q,
                            input logic [63:0] exp_r, input logic [63:0] exp_z);
        int dcyc;
        int bcnt;
        run_op(p, q, dcyc, bcnt);
        chk({tag, "_done_cycle"}, 64'(dcyc), 64'(exp_cyc));
        chk({tag, "_quotient"},   64'(bus.quotient), exp_q);
        chk({tag, "_remainder"},  64'(bus.remainder), exp_r);
        chk({tag, "_dbz"},        64'(bus.divideByZero), exp_z);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int dcyc, bcnt, d1, d2, ndone;
        logic [2*W-1:0] q1, q2, qmid;
        logic [W-1:0]   r1, r2;

        bus.start  = 1'b0;
        bus.inputP = '0;
        bus.inputQ = '0;

        // 1. reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ready", 64'(bus.ready), 64'd1);
        chk("rst_busy",  64'(bus.busy),  64'd0);
        chk("rst_done",  64'(bus.done),  64'd0);
        chk("rst_quo",   64'(bus.quotient),  64'd0);
        chk("rst_rem",   64'(bus.remainder), 64'd0);
        chk("rst_dbz",   64'(bus.divideByZero), 64'd0);

        // 2. basic 100/7 with busy window and single-cycle done
        run_op(16'd100, 16'd7, dcyc, bcnt);
        chk("t2_done_cycle", 64'(dcyc), 64'd17);
        chk("t2_busy_cycles", 64'(bcnt), 64'd16);
        chk("t2_quotient", 64'(bus.quotient), 64'd14);
        chk("t2_remainder", 64'(bus.remainder), 64'd2);
        chk("t2_dbz", 64'(bus.divideByZero), 64'd0);
        chk("t2_ready_in_done", 64'(bus.ready), 64'd1);
        tick();
        chk("t2_done_pulse", 64'(bus.done), 64'd0);
        chk("t2_idle_ready", 64'(bus.ready), 64'd1);
        chk("t2_hold_quo", 64'(bus.quotient), 64'd14);

        // 3. divide by zero, then a normal op clears the flag
        op_check("t3_dbz", 16'd5, 16'd0, 1, 64'd0, 64'd5, 64'd1);
        op_check("t3_next", 16'd9, 16'd3, 17, 64'd3, 64'd0, 64'd0);

        // 4. starts while busy ignored; back-to-back start during done
        bus.start  = 1'b1;
        bus.inputP = 16'hFFFF;
        bus.inputQ = 16'd1;
        tick();
        d1 = -1; d2 = -1; ndone = 0;
        q1 = '0; q2 = '0; r1 = '0; r2 = '0; qmid = '0;
        for (int c = 1; c <= 60; c++) begin
            if (bus.done) begin
                ndone++;
                if (d1 < 0) begin
                    d1 = c; q1 = bus.quotient; r1 = bus.remainder;
                end else if (d2 < 0) begin
                    d2 = c; q2 = bus.quotient; r2 = bus.remainder;
                end
            end
            if (c == 20) qmid = bus.quotient;
            if (c == 3 || c == 10) begin
                bus.start = 1'b1; bus.inputP = 16'd1; bus.inputQ = 16'd1;
            end else if (c == 17) begin
                bus.start = 1'b1; bus.inputP = 16'd200; bus.inputQ = 16'd9;
            end else begin
                bus.start = 1'b0;
            end
            if (d2 >= 0) break;
            tick();
        end
        bus.start = 1'b0;
        chk("t4_first_done", 64'(d1), 64'd17);
`ifdef DIV_SIGNED_EN
        chk("t4_first_quo", 64'(q1), 64'hFFFF_FFFF);
        chk("t4_held_quo", 64'(qmid), 64'hFFFF_FFFF);
`else
        chk("t4_first_quo", 64'(q1), 64'h0000_FFFF);
        chk("t4_held_quo", 64'(qmid), 64'h0000_FFFF);
`endif
        chk("t4_first_rem", 64'(r1), 64'd0);
        chk("t4_second_done", 64'(d2), 64'd34);
        chk("t4_second_quo", 64'(q2), 64'd22);
        chk("t4_second_rem", 64'(r2), 64'd2);
        chk("t4_done_count", 64'(ndone), 64'd2);
        tick();

        // 5. reset mid-operation
        bus.start  = 1'b1;
        bus.inputP = 16'd1000;
        bus.inputQ = 16'd10;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c < 8; c++) tick();
        chk("t5_busy_before_rst", 64'(bus.busy), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_ready", 64'(bus.ready), 64'd1);
        chk("t5_busy",  64'(bus.busy),  64'd0);
        chk("t5_quo",   64'(bus.quotient),  64'd0);
        chk("t5_rem",   64'(bus.remainder), 64'd0);
        ndone = 0;
        for (int c = 0; c < 30; c++) begin
            if (bus.done) ndone++;
            tick();
        end
        chk("t5_no_done", 64'(ndone), 64'd0);

        // boundaries and a wide operand
        op_check("b_p_lt_q", 16'd3, 16'd10, 17, 64'd0, 64'd3, 64'd0);
        op_check("b_p_zero", 16'd0, 16'd5, 17, 64'd0, 64'd0, 64'd0);
`ifdef DIV_SIGNED_EN
        op_check("b_wide", 16'd40000, 16'd300, 17, 64'hFFFF_FFAB, 64'hFFDC, 64'd0);

        // 6. signed cases
        op_check("t6_neg7_div2", 16'hFFF9, 16'd2, 17, 64'hFFFF_FFFD, 64'hFFFF, 64'd0);
        op_check("t6_min_div_m1", 16'h8000, 16'hFFFF, 17, 64'h0000_8000, 64'd0, 64'd0);
        op_check("t6_neg_dbz", 16'hFFFB, 16'd0, 1, 64'd0, 64'hFFFB, 64'd1);
`else
        op_check("b_wide", 16'd40000, 16'd300, 17, 64'd133, 64'd100, 64'd0);
        op_check("b_all_ones", 16'hFFFF, 16'h8000, 17, 64'd1, 64'h7FFF, 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
